jtag_dr_controller: RTL and testbench
=====================================

# jtag_dr_controller

Instruction and data-register scan controller for the JTAG port. It sits behind the TAP state machine and consumes its state code on every `tck` edge. It owns the 4-bit instruction register and the BYPASS, IDCODE and USER data registers, and drives `tdo` from the selected register. USER updates are forwarded to the core through a valid/ready handshake.

## Interface
Parameters:
- `IDCODE`, 32'h000F_AF01, value loaded into the IDCODE DR at Capture-DR.
- `USER_WIDTH`, 16, USER DR width; legal range 1..32.

Ports:
- `tck`  in  1  JTAG clock; all state updates on posedge.
- `trst_n`  in  1  asynchronous, active-low reset.
- `tdi`  in  1  serial data in.
- `tap_state`  in  5  TAP state code. Decoded codes: TestLogicReset 5'h00, CaptureDr 5'h04, CaptureIr 5'h05, ShiftDr 5'h06, ShiftIr 5'h07, UpdateDr 5'h14, UpdateIr 5'h15. All other codes mean hold.
- `tdo`  out  1  serial data out.
- `ir`  out  4  current instruction.
- `user_rd_data`  in  USER_WIDTH  value captured into the USER DR.
- `user_wr_data`  out  USER_WIDTH  last USER DR update.
- `user_wr_valid`  out  1  `user_wr_data` pending.
- `user_wr_ready`  in  1  core accepts the pending write.
- `user_overrun`  out  1  sticky: an update was dropped because a write was still pending.
- `length_error`  out  1  sticky USER shift-length mismatch. Tied 0 when the length check is compiled out.

## Operation
- Instructions:
  - 4'b1110 IDCODE.
  - 4'b1111 BYPASS.
  - 4'b1010 USER.
  - Any other code, including ABORT 4'b1000, selects BYPASS.
- IR path:
  - CaptureIr: `ir_shift` <= 4'b0001.
  - ShiftIr: `ir_shift` <= {tdi, ir_shift[3:1]}.
  - UpdateIr: `ir` <= `ir_shift`.
- DR path, selected by `ir`:
  - CaptureDr: bypass <= 0, idcode_sr <= IDCODE, user_sr <= `user_rd_data`, `dr_count` <= 0.
  - ShiftDr: the selected register shifts right with `tdi` entering the MSB; unselected registers hold. `dr_count` increments and saturates at 63.
  - After the full register length, `tdo` returns the `tdi` stream delayed by that length.
- USER write launch: UpdateDr with `ir`==USER (length check permitting) launches a write.
  - No write pending: `user_wr_data` <= user_sr and `user_wr_valid` <= 1.
  - Write pending and `user_wr_ready`=1 in the same cycle: the old write completes, the new data loads, and valid stays 1.
  - Write pending and `user_wr_ready`=0: new data is dropped, `user_wr_data` is unchanged, and `user_overrun` <= 1.
- Handshake:
  - A transfer occurs on a posedge with valid&&ready; valid then clears unless a new launch occurs the same cycle.
  - `user_wr_data` is stable while valid is high.
- TestLogicReset state (synchronous): `ir` <= 4'b1110; `user_overrun` and `length_error` clear.
  - A pending write is not cancelled.
- Reset (`trst_n`=0, asynchronous):
  - `ir`=4'b1110, `ir_shift`=0, all DRs 0, `dr_count`=0.
  - `tdo`=0, `user_wr_valid`=0, `user_wr_data`=0, `user_overrun`=0, `length_error`=0.

## Timing
- `tdo` is combinational:
  - ShiftIr: ir_shift[0].
  - ShiftDr: LSB of the selected DR.
  - Otherwise 0.
- The first `tdo` bit of a scan is bit 0 of the captured value, valid during the first ShiftDr/ShiftIr cycle. Bit n is valid during the (n+1)th shift cycle.
- `ir` changes on the posedge where `tap_state`==UpdateIr; the new selection applies to the next Capture-DR.
- `user_wr_valid` rises on the posedge where `tap_state`==UpdateDr, visible the following cycle. Minimum launch-to-accept latency is 1 cycle.
- Reset deassertion is synchronized externally; the block adds no reset-release latency.

## Configuration
- `JTAG_DR_LENGTH_CHECK_EN` defined:
  - A USER UpdateDr launches only if `dr_count`==USER_WIDTH.
  - Otherwise no write launches and `length_error` <= 1.
- Undefined: every USER UpdateDr launches regardless of shift count, `length_error` is constant 0, and the comparison logic is absent.

## Test plan
- Reset, CaptureDr, then 32× ShiftDr with tdi=0 → `tdo` LSB-first = 32'h000F_AF01 (1,0,0,0,0,0,0,0,1,1,1,1,0,1,0,1,...), followed by 0s.
- IR scan shifting 4'b1111 → `tdo`=1,0,0,0; after UpdateIr `ir`=4'b1111. Following DR scan with tdi=1,0,1 → `tdo`=0,1,0.
- `ir`=USER, `user_rd_data`=16'hBEEF, shift in 16'h1234 → `tdo` emits 16'hBEEF LSB-first. After UpdateDr, valid=1 and data=16'h1234; ready held low 3 cycles then high → valid drops one cycle after the accept edge.
- Two USER updates (0x1234, then 0x5678) with ready low → data stays 0x1234 and `user_overrun`=1. Then TestLogicReset → `user_overrun`=0, `ir`=4'b1110, valid still 1.
- With `JTAG_DR_LENGTH_CHECK_EN`, 15-bit USER shift → no valid, `length_error`=1. Without the macro → valid=1 with the partially shifted value.
- `trst_n` low mid-ShiftDr → all outputs reset immediately (no clock edge), `tdo`=0, `ir`=4'b1110.

Source files
------------

// File: rtl/jtag_dr_controller.sv
// JTAG instruction/data-register scan controller driven by the TAP state code.
// Define JTAG_DR_LENGTH_CHECK_EN to reject USER updates whose shift count differs from USER_WIDTH.
module jtag_dr_controller #(
    parameter logic [31:0] IDCODE     = 32'h000F_AF01,
    parameter int          USER_WIDTH = 16
) (
    input  logic                  tck,
    input  logic                  trst_n,
    input  logic                  tdi,
    input  logic [4:0]            tap_state,
    output logic                  tdo,
    output logic [3:0]            ir,
    input  logic [USER_WIDTH-1:0] user_rd_data,
    output logic [USER_WIDTH-1:0] user_wr_data,
    output logic                  user_wr_valid,
    input  logic                  user_wr_ready,
    output logic                  user_overrun,
    output logic                  length_error
);

    typedef enum logic [4:0] {
        TAP_TEST_LOGIC_RESET = 5'h00,
        TAP_CAPTURE_DR       = 5'h04,
        TAP_CAPTURE_IR       = 5'h05,
        TAP_SHIFT_DR         = 5'h06,
        TAP_SHIFT_IR         = 5'h07,
        TAP_UPDATE_DR        = 5'h14,
        TAP_UPDATE_IR        = 5'h15
    } tap_state_t;

    localparam logic [3:0] IR_IDCODE = 4'b1110;
    localparam logic [3:0] IR_USER   = 4'b1010;

    logic [3:0]            ir_shift;
    logic                  bypass_reg;
    logic [31:0]           idcode_sr;
    logic [USER_WIDTH-1:0] user_sr;
    logic [USER_WIDTH-1:0] user_shifted;
    logic                  sel_idcode;
    logic                  sel_user;
    logic                  length_ok;
    logic                  launch;

    assign sel_idcode = (ir == IR_IDCODE);
    assign sel_user   = (ir == IR_USER);

    always_comb begin
        user_shifted = user_sr >> 1;
        user_shifted[USER_WIDTH-1] = tdi;
    end

    always_comb begin
        tdo = 1'b0;
        case (tap_state)
            TAP_SHIFT_IR: tdo = ir_shift[0];
            TAP_SHIFT_DR: tdo = sel_user ? user_sr[0] : (sel_idcode ? idcode_sr[0] : bypass_reg);
            default:      tdo = 1'b0;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir         <= IR_IDCODE;
            ir_shift   <= 4'b0000;
            bypass_reg <= 1'b0;
            idcode_sr  <= '0;
            user_sr    <= '0;
        end else begin
            case (tap_state)
                TAP_TEST_LOGIC_RESET: ir       <= IR_IDCODE;
                TAP_CAPTURE_IR:       ir_shift <= 4'b0001;
                TAP_SHIFT_IR:         ir_shift <= {tdi, ir_shift[3:1]};
                TAP_UPDATE_IR:        ir       <= ir_shift;
                TAP_CAPTURE_DR: begin
                    bypass_reg <= 1'b0;
                    idcode_sr  <= IDCODE;
                    user_sr    <= user_rd_data;
                end
                TAP_SHIFT_DR: begin
                    if (sel_user)
                        user_sr <= user_shifted;
                    else if (sel_idcode)
                        idcode_sr <= {tdi, idcode_sr[31:1]};
                    else
                        bypass_reg <= tdi;
                end
                default: ;
            endcase
        end
    end

`ifdef JTAG_DR_LENGTH_CHECK_EN
    localparam logic [5:0] USER_LEN = 6'(USER_WIDTH);

    logic [5:0] dr_count;

    assign length_ok = (dr_count == USER_LEN);

    // Shift counter saturates so very long scans still read as a mismatch.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            dr_count     <= 6'd0;
            length_error <= 1'b0;
        end else begin
            if (tap_state == TAP_CAPTURE_DR)
                dr_count <= 6'd0;
            else if (tap_state == TAP_SHIFT_DR && dr_count != 6'd63)
                dr_count <= dr_count + 6'd1;

            if (tap_state == TAP_TEST_LOGIC_RESET)
                length_error <= 1'b0;
            else if (tap_state == TAP_UPDATE_DR && sel_user && !length_ok)
                length_error <= 1'b1;
        end
    end
`else
    assign length_ok    = 1'b1;
    assign length_error = 1'b0;
`endif

    assign launch = (tap_state == TAP_UPDATE_DR) && sel_user && length_ok;

    // A launch while a write is pending only succeeds if that write is accepted on the same edge.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            user_wr_data  <= '0;
            user_wr_valid <= 1'b0;
            user_overrun  <= 1'b0;
        end else begin
            if (tap_state == TAP_TEST_LOGIC_RESET)
                user_overrun <= 1'b0;

            if (launch) begin
                if (!user_wr_valid || user_wr_ready) begin
                    user_wr_data  <= user_sr;
                    user_wr_valid <= 1'b1;
                end else begin
                    user_overrun <= 1'b1;
                end
            end else if (user_wr_valid && user_wr_ready) begin
                user_wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_dr_controller.sv
// Scoreboard bench for jtag_dr_controller: tdo bits and accepted USER writes are checked by monitors.
module tb_jtag_dr_controller;

    localparam logic [4:0] ST_TLR     = 5'h00;
    localparam logic [4:0] ST_HOLD    = 5'h01;
    localparam logic [4:0] ST_CAP_DR  = 5'h04;
    localparam logic [4:0] ST_CAP_IR  = 5'h05;
    localparam logic [4:0] ST_SHIFT_DR = 5'h06;
    localparam logic [4:0] ST_SHIFT_IR = 5'h07;
    localparam logic [4:0] ST_UPD_DR  = 5'h14;
    localparam logic [4:0] ST_UPD_IR  = 5'h15;

    logic        tck = 1'b0;
    logic        trst_n;
    logic        tdi;
    logic [4:0]  tap_state;
    logic        tdo;
    logic [3:0]  ir;
    logic [15:0] user_rd_data;
    logic [15:0] user_wr_data;
    logic        user_wr_valid;
    logic        user_wr_ready;
    logic        user_overrun;
    logic        length_error;

    logic        exp_tdo[$];
    logic [15:0] exp_wr[$];
    logic        mon_tdo_exp;
    logic [15:0] mon_wr_exp;
    int          checks = 0;
    int          failures = 0;
    int          tdo_idx = 0;

    jtag_dr_controller #(.IDCODE(32'h000F_AF01), .USER_WIDTH(16)) dut (
        .tck          (tck),
        .trst_n       (trst_n),
        .tdi          (tdi),
        .tap_state    (tap_state),
        .tdo          (tdo),
        .ir           (ir),
        .user_rd_data (user_rd_data),
        .user_wr_data (user_wr_data),
        .user_wr_valid(user_wr_valid),
        .user_wr_ready(user_wr_ready),
        .user_overrun (user_overrun),
        .length_error (length_error)
    );

    always #5 tck = ~tck;

    // Monitor: every shift cycle pops one expected tdo bit; every accept pops one expected write.
    always @(negedge tck) begin
        if (trst_n && (tap_state == ST_SHIFT_DR || tap_state == ST_SHIFT_IR)) begin
            checks++;
            if (exp_tdo.size() == 0) begin
                failures++;
                $display("[TB] FAIL tdo_unexpected bit=%0d actual=%b required=none", tdo_idx, tdo);
            end else begin
                mon_tdo_exp = exp_tdo.pop_front();
                if (tdo !== mon_tdo_exp) begin
                    failures++;
                    $display("[TB] FAIL tdo bit=%0d actual=%b required=%b", tdo_idx, tdo, mon_tdo_exp);
                end
            end
            tdo_idx++;
        end
        if (trst_n && user_wr_valid && user_wr_ready) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("[TB] FAIL wr_unexpected actual=%h required=none", user_wr_data);
            end else begin
                mon_wr_exp = exp_wr.pop_front();
                if (user_wr_data !== mon_wr_exp) begin
                    failures++;
                    $display("[TB] FAIL wr_data actual=%h required=%h", user_wr_data, mon_wr_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [4:0] st, input logic d);
        tap_state = st;
        tdi       = d;
        @(posedge tck);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic shiftDr(input logic [63:0] din, input logic [63:0] dexp, input int n);
        for (int i = 0; i < n; i++) begin
            exp_tdo.push_back(dexp[i]);
            applyStimulus(ST_SHIFT_DR, din[i]);
        end
    endtask

    task automatic loadIr(input logic [3:0] value);
        applyStimulus(ST_CAP_IR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_tdo.push_back(i == 0);
            applyStimulus(ST_SHIFT_IR, value[i]);
        end
        applyStimulus(ST_UPD_IR, 1'b0);
        applyStimulus(ST_HOLD, 1'b0);
    endtask

    task automatic userScan(input logic [15:0] din, input int n, input logic rdy_at_update);
        applyStimulus(ST_CAP_DR, 1'b0);
        shiftDr({48'h0, din}, {48'h0, user_rd_data}, n);
        user_wr_ready = rdy_at_update;
        applyStimulus(ST_UPD_DR, 1'b0);
        user_wr_ready = 1'b0;
    endtask

    task automatic drainWrite();
        user_wr_ready = 1'b1;
        applyStimulus(ST_HOLD, 1'b0);
        user_wr_ready = 1'b0;
    endtask

    initial begin
        trst_n        = 1'b0;
        tap_state     = ST_TLR;
        tdi           = 1'b0;
        user_wr_ready = 1'b0;
        user_rd_data  = 16'hBEEF;
        #12;
        checkOutput("reset_ir", {28'h0, ir}, 32'hE);
        checkOutput("reset_tdo", {31'h0, tdo}, 32'h0);
        checkOutput("reset_valid", {31'h0, user_wr_valid}, 32'h0);
        checkOutput("reset_data", {16'h0, user_wr_data}, 32'h0);
        checkOutput("reset_overrun", {31'h0, user_overrun}, 32'h0);
        checkOutput("reset_length_error", {31'h0, length_error}, 32'h0);
        @(posedge tck);
        #1;
        trst_n = 1'b1;
        applyStimulus(ST_HOLD, 1'b0);

        // IDCODE scan: 32 captured bits then the zero tdi stream
        applyStimulus(ST_CAP_DR, 1'b0);
        shiftDr(64'h0, 64'h0000_0000_000F_AF01, 36);
        applyStimulus(ST_HOLD, 1'b0);

        // IR scan to BYPASS, then a three-bit bypass scan
        loadIr(4'b1111);
        checkOutput("ir_bypass", {28'h0, ir}, 32'hF);
        applyStimulus(ST_CAP_DR, 1'b0);
        shiftDr(64'h5, 64'h2, 3);
        applyStimulus(ST_HOLD, 1'b0);

        // USER scan with a slow consumer
        loadIr(4'b1010);
        checkOutput("ir_user", {28'h0, ir}, 32'hA);
        exp_wr.push_back(16'h1234);
        userScan(16'h1234, 16, 1'b0);
        checkOutput("user_valid_after_update", {31'h0, user_wr_valid}, 32'h1);
        checkOutput("user_data_after_update", {16'h0, user_wr_data}, 32'h1234);
        checkOutput("length_error_full_scan", {31'h0, length_error}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ST_HOLD, 1'b0);
            checkOutput("user_valid_held", {31'h0, user_wr_valid}, 32'h1);
        end
        drainWrite();
        checkOutput("user_valid_after_accept", {31'h0, user_wr_valid}, 32'h0);

        // Second update while pending is dropped and flagged
        exp_wr.push_back(16'h1234);
        userScan(16'h1234, 16, 1'b0);
        userScan(16'h5678, 16, 1'b0);
        checkOutput("overrun_data_kept", {16'h0, user_wr_data}, 32'h1234);
        checkOutput("overrun_set", {31'h0, user_overrun}, 32'h1);
        applyStimulus(ST_TLR, 1'b0);
        checkOutput("tlr_overrun_clear", {31'h0, user_overrun}, 32'h0);
        checkOutput("tlr_ir", {28'h0, ir}, 32'hE);
        checkOutput("tlr_valid_kept", {31'h0, user_wr_valid}, 32'h1);
        drainWrite();
        checkOutput("tlr_drained", {31'h0, user_wr_valid}, 32'h0);

        // Back-to-back: accept and relaunch on the same edge
        loadIr(4'b1010);
        exp_wr.push_back(16'hA5A5);
        userScan(16'hA5A5, 16, 1'b0);
        exp_wr.push_back(16'h0F0F);
        userScan(16'h0F0F, 16, 1'b1);
        checkOutput("b2b_valid", {31'h0, user_wr_valid}, 32'h1);
        checkOutput("b2b_data", {16'h0, user_wr_data}, 32'h0F0F);
        checkOutput("b2b_overrun", {31'h0, user_overrun}, 32'h0);
        drainWrite();

        // Short 15-bit USER scan
`ifdef JTAG_DR_LENGTH_CHECK_EN
        userScan(16'h1234, 15, 1'b0);
        checkOutput("short_valid", {31'h0, user_wr_valid}, 32'h0);
        checkOutput("short_length_error", {31'h0, length_error}, 32'h1);
`else
        exp_wr.push_back(16'h2469);
        userScan(16'h1234, 15, 1'b0);
        checkOutput("short_valid", {31'h0, user_wr_valid}, 32'h1);
        checkOutput("short_data", {16'h0, user_wr_data}, 32'h2469);
        checkOutput("short_length_error", {31'h0, length_error}, 32'h0);
        drainWrite();
`endif

        // Asynchronous reset in the middle of a USER ShiftDr with a write pending
        applyStimulus(ST_TLR, 1'b0);
        loadIr(4'b1010);
        userScan(16'h3C3C, 16, 1'b0);
        checkOutput("pre_reset_valid", {31'h0, user_wr_valid}, 32'h1);
        applyStimulus(ST_CAP_DR, 1'b0);
        tap_state = ST_SHIFT_DR;
        #1;
        checkOutput("pre_reset_tdo", {31'h0, tdo}, 32'h1);
        #1;
        trst_n = 1'b0;
        #1;
        checkOutput("async_tdo", {31'h0, tdo}, 32'h0);
        checkOutput("async_ir", {28'h0, ir}, 32'hE);
        checkOutput("async_valid", {31'h0, user_wr_valid}, 32'h0);
        checkOutput("async_data", {16'h0, user_wr_data}, 32'h0);
        checkOutput("async_overrun", {31'h0, user_overrun}, 32'h0);
        tap_state = ST_TLR;
        applyStimulus(ST_TLR, 1'b0);
        trst_n = 1'b1;
        applyStimulus(ST_HOLD, 1'b0);

        checkOutput("tdo_queue_empty", exp_tdo.size(), 32'h0);
        checkOutput("wr_queue_empty", exp_wr.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
